rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 mux-driven resource (e.g. a shared write port or bus) among four requesters.
- Produces a registered one-hot grant plus the 2-bit select that drives the mux4 select input. Sel is stable for the whole ownership period.
- Bounds each ownership period to MAX_HOLD cycles when other requesters are waiting, so no requester starves.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 35 +++
 rtl/rr_mux4_arbiter.sv | 122 ++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Holds the requester count, select width, FSM encoding and a one-hot helper.
package rr_arb_pkg;

  localparam int NREQ         = 4;
  localparam int SEL_W        = 2;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: searches last+1, last+2, last+3, last (mod 4)
// and can mask one index so the top level can ask "who else is waiting".
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0]  cand;
  logic [SEL_W-1:0] cidx;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cand  = req;
    found = 1'b0;
    idx   = last;
    cidx  = last;
    if (excl_en) cand[excl_idx] = 1'b0;
    // Walk from lowest to highest priority so the nearest match wins last.
    for (int k = NREQ; k >= 1; k--) begin
      cidx = last + SEL_W'(k);
      if (cand[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux resource with registered one-hot
// grant, stable mux select and a hold limit that bounds each ownership period.
module rr_mux4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [SEL_W-1:0] last, last_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [NREQ-1:0]  grant_nxt;
  logic             busy_nxt;

  logic             any_found, oth_found;
  logic [SEL_W-1:0] any_idx, oth_idx;
  logic             win_en;
  logic [SEL_W-1:0] win_idx;

  rr_pick4 u_pick_any (
    .req      (req),
    .excl_en  (1'b0),
    .excl_idx (sel),
    .last     (last),
    .found    (any_found),
    .idx      (any_idx)
  );

  // The owner is sel, so this instance answers "is anyone else waiting".
  rr_pick4 u_pick_oth (
    .req      (req),
    .excl_en  (1'b1),
    .excl_idx (sel),
    .last     (last),
    .found    (oth_found),
    .idx      (oth_idx)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    last_nxt  = last;
    sel_nxt   = sel;
    grant_nxt = grant;
    busy_nxt  = busy;
    win_en    = 1'b0;
    win_idx   = any_idx;

    unique case (state)
      IDLE: begin
        if (any_found) begin
          win_en  = 1'b1;
          win_idx = any_idx;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          if (oth_found) begin
            win_en  = 1'b1;
            win_idx = oth_idx;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            count_nxt = '0;
          end
        end else if (count == HOLD_LAST) begin
          // A lone owner keeps the bus across its timeout; only the count restarts.
          if (oth_found) begin
            win_en  = 1'b1;
            win_idx = oth_idx;
          end else begin
            count_nxt = '0;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
    endcase

    if (win_en) begin
      state_nxt = GRANT;
      grant_nxt = onehot(win_idx);
      sel_nxt   = win_idx;
      last_nxt  = win_idx;
      busy_nxt  = 1'b1;
      count_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      last  <= SEL_W'(NREQ - 1);
      sel   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: an ownership-level model is compared every cycle,
// and directed scenarios pin the model with hand-computed literal values.
module tb_rr_mux4_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  rr_mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the resource, for how many cycles it has visibly held it,
  // who owned it last, and what the mux select shows.
  int m_owner  = -1;
  int m_tenure = 0;
  int m_last   = 3;
  int m_sel    = 0;
  bit m_valid  = 1'b0;

  function automatic int first_pending(input logic [3:0] r, input int from, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_give(input int w);
    m_owner  = w;
    m_last   = w;
    m_sel    = w;
    m_tenure = 1;
  endtask

  always @(posedge clk) begin
    int other;
    if (!rst_n) begin
      m_owner  = -1;
      m_tenure = 0;
      m_last   = 3;
      m_sel    = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        other = first_pending(req, m_last, -1);
        if (other >= 0) model_give(other);
      end else begin
        other = first_pending(req, m_owner, m_owner);
        if (!req[m_owner]) begin
          if (other >= 0) model_give(other);
          else m_owner = -1;
        end else if (m_tenure == MAX_HOLD) begin
          if (other >= 0) model_give(other);
          else m_tenure = 1;
        end else begin
          m_tenure++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    if (m_valid) begin
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      check("model_grant", 32'(grant), 32'(eg));
      check("model_sel",   32'(sel),   32'(m_sel));
      check("model_busy",  32'(busy),  32'(m_owner >= 0));
    end
  end

  task automatic apply(input logic [3:0] r, input int n);
    req = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({name, "_grant"}, 32'(grant), 32'(g));
    check({name, "_sel"},   32'(sel),   32'(s));
    check({name, "_busy"},  32'(busy),  32'(b));
  endtask

  typedef struct {
    logic [3:0] r;
    int         n;
  } vec_t;

  vec_t tbl[7] = '{
    '{4'b0110, 6}, '{4'b0011, 9}, '{4'b1111, 3}, '{4'b0000, 2},
    '{4'b1000, 1}, '{4'b0111, 10}, '{4'b0000, 3}
  };

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(negedge clk);
    lit("reset", 4'b0000, 2'd0, 1'b0);

    rst_n = 1'b1;
    apply(4'b1111, 1); lit("first_grant", 4'b0001, 2'd0, 1'b1);
    apply(4'b1111, 3); lit("rot0_end",    4'b0001, 2'd0, 1'b1);
    apply(4'b1111, 1); lit("rot1_start",  4'b0010, 2'd1, 1'b1);
    apply(4'b1111, 3); lit("rot1_end",    4'b0010, 2'd1, 1'b1);
    apply(4'b1111, 1); lit("rot2_start",  4'b0100, 2'd2, 1'b1);
    apply(4'b1111, 4); lit("rot3_start",  4'b1000, 2'd3, 1'b1);
    apply(4'b1111, 4); lit("rot_wrap",    4'b0001, 2'd0, 1'b1);

    apply(4'b0101, 1); lit("hold_r0",     4'b0001, 2'd0, 1'b1);
    apply(4'b0100, 1); lit("handoff_r2",  4'b0100, 2'd2, 1'b1);

    apply(4'b1000, 1); lit("sole_first",  4'b1000, 2'd3, 1'b1);
    apply(4'b1000, 9); lit("sole_after",  4'b1000, 2'd3, 1'b1);
    apply(4'b0000, 1); lit("sole_drop",   4'b0000, 2'd3, 1'b0);

    apply(4'b1001, 1); lit("wrap_prio",   4'b0001, 2'd0, 1'b1);

    apply(4'b0100, 1); lit("pre_reset",   4'b0100, 2'd2, 1'b1);
    rst_n = 1'b0;
    apply(4'b1111, 1); lit("mid_reset",   4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    apply(4'b1111, 1); lit("post_reset",  4'b0001, 2'd0, 1'b1);

    foreach (tbl[i]) apply(tbl[i].r, tbl[i].n);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
